// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - iterative shift-add multiplier / restoring divider for EX
module muldiv_iter #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic [1:0]         op_i,
   input  logic [WIDTH-1:0]   opa_i,
   input  logic [WIDTH-1:0]   opb_i,
   input  logic               annul_i,
   output logic               busy_o,
   output logic               ready_o,
   output logic [2*WIDTH-1:0] result_o
);

   localparam int W  = WIDTH;
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [W-1:0]   ONE_W  = 1;
   localparam logic [2*W-1:0] ONE_2W = 1;
   localparam logic [CW-1:0]  ONE_C  = 1;
   localparam logic [CW-1:0]  LAST_C = CW'(W);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DIVZ, S_DONE} state_t;

   state_t         state_q, state_d;
   logic           is_div_q;
   logic           neg_quo_q;   // quotient / product sign
   logic           neg_rem_q;   // remainder takes the dividend's sign
   logic [W-1:0]   x_q;         // |multiplicand| or |divisor|
   logic [W-1:0]   opa_raw_q;   // original dividend for the divide-by-zero result
   logic [2*W-1:0] acc_q;       // mul: {hi, multiplier/lo}; div: {rem, dividend/quot}
   logic [CW-1:0]  cnt_q;
   logic [2*W-1:0] result_q;

   logic [W-1:0]   a_abs, b_abs;
   logic [W:0]     mul_sum, div_trial;
   logic [2*W-1:0] acc_step, fix_res;
   logic [W-1:0]   quo_fix, rem_fix;
   logic           go;

   assign go    = start_i && !annul_i;
   assign a_abs = (op_i[0] && opa_i[W-1]) ? (~opa_i + ONE_W) : opa_i;
   assign b_abs = (op_i[0] && opb_i[W-1]) ? (~opb_i + ONE_W) : opb_i;

   // State register; rst overrides everything, including an operation in flight
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state: annul returns to IDLE from any busy state without a ready pulse
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (go) state_d = (op_i[1] && opb_i == '0) ? S_DIVZ : S_RUN;
         S_RUN:  if (annul_i) state_d = S_IDLE;
                 else if (cnt_q == LAST_C) state_d = S_DONE;
         S_DIVZ: state_d = annul_i ? S_IDLE : S_DONE;
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs: busy outside IDLE, ready only in an un-annulled DONE cycle
   always_comb begin
      busy_o   = (state_q != S_IDLE);
      ready_o  = (state_q == S_DONE) && !annul_i;
      result_o = result_q;
   end

   // One iteration of shift-add (mul) or restoring subtract (div) on the accumulator
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*W-1:W]} + {1'b0, x_q};
      div_trial = acc_q[2*W-1:W-1] - {1'b0, x_q};
      if (is_div_q) begin
         if (!div_trial[W]) acc_step = {div_trial[W-1:0], acc_q[W-2:0], 1'b1};
         else               acc_step = {acc_q[2*W-2:0], 1'b0};
      end else if (acc_q[0]) begin
         acc_step = {mul_sum, acc_q[W-1:1]};
      end else begin
         acc_step = {1'b0, acc_q[2*W-1:1]};
      end
   end

   // Sign fix-up of the finished magnitude result; MIN / -1 needs no special case
   always_comb begin
      quo_fix = neg_quo_q ? (~acc_q[W-1:0] + ONE_W) : acc_q[W-1:0];
      rem_fix = neg_rem_q ? (~acc_q[2*W-1:W] + ONE_W) : acc_q[2*W-1:W];
      if (is_div_q) fix_res = {rem_fix, quo_fix};
      else          fix_res = neg_quo_q ? (~acc_q + ONE_2W) : acc_q;
   end

   // Datapath: latch operands on start, iterate in RUN, load result on entry to DONE
   always_ff @(posedge clk) begin
      if (rst) begin
         is_div_q  <= 1'b0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         x_q       <= '0;
         opa_raw_q <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         result_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (go) begin
                  is_div_q  <= op_i[1];
                  neg_quo_q <= op_i[0] & (opa_i[W-1] ^ opb_i[W-1]);
                  neg_rem_q <= op_i[0] & opa_i[W-1];
                  opa_raw_q <= opa_i;
                  cnt_q     <= '0;
                  if (op_i[1]) begin
                     x_q   <= b_abs;
                     acc_q <= {{W{1'b0}}, a_abs};
                  end else begin
                     x_q   <= a_abs;
                     acc_q <= {{W{1'b0}}, b_abs};
                  end
               end
            end
            S_RUN: begin
               if (!annul_i) begin
                  if (cnt_q == LAST_C) begin
                     result_q <= fix_res;
                  end else begin
                     acc_q <= acc_step;
                     cnt_q <= cnt_q + ONE_C;
                  end
               end
            end
            S_DIVZ: begin
               if (!annul_i) result_q <= {opa_raw_q, {W{1'b1}}};
            end
            default: ;
         endcase
      end
   end

endmodule
